// File: rtl/cla4_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract built around a single 4-bit carry-lookahead slice.
// Latency: done pulses WIDTH/4 clock edges after the edge that accepted start.
// Backpressure: ready is low while a nibble sweep is running; start is ignored then.

module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       carryIn,
    output logic [3:0] s,
    output logic       carryOut
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Generate/propagate lookahead: every internal carry is a flat function of g, p and carryIn.
    always_comb begin
        g        = x & y;
        p        = x ^ y;
        c[0]     = carryIn;
        c[1]     = g[0] | (p[0] & carryIn);
        c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carryIn);
        c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carryIn);
        carryOut = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & carryIn);
        s        = p ^ c;
    end
endmodule

module cla4_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryInput,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOutput,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] nextPartial;
    logic             cReg;
    logic [CW-1:0]    cnt;
    logic [CW+1:0]    base;
    logic [3:0]       sliceSum;
    logic             sliceCarry;

    assign base = {cnt, 2'b00};

    cla4 slice (
        .x        (aReg[base +: 4]),
        .y        (bEff[base +: 4]),
        .carryIn  (cReg),
        .s        (sliceSum),
        .carryOut (sliceCarry)
    );

    // Partial sum with the current nibble merged in; on the last nibble this is the full result.
    always_comb begin
        nextPartial              = partial;
        nextPartial[base +: 4]   = sliceSum;
    end

    // Sequencer: capture operands on accept, sweep nibbles LSB first, publish result on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            sum         <= '0;
            carryOutput <= 1'b0;
            overflow    <= 1'b0;
            aReg        <= '0;
            bEff        <= '0;
            partial     <= '0;
            cReg        <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        aReg  <= a;
                        bEff  <= op ? ~b : b;
                        cReg  <= op ? 1'b1 : carryInput;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    partial <= nextPartial;
                    cReg    <= sliceCarry;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        ready       <= 1'b1;
                        done        <= 1'b1;
                        sum         <= nextPartial;
                        carryOutput <= sliceCarry;
                        // Carry into the MSB is a^b^sum at that bit; XOR with carry-out flags signed overflow.
                        overflow    <= aReg[WIDTH-1] ^ bEff[WIDTH-1] ^ nextPartial[WIDTH-1] ^ sliceCarry;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla4_serial_adder_ctrl.sv
// Bench for the nibble-serial adder: three widths (4, 16, 32) share one stimulus stream.
// A reference model tracks accepted operations and expected done timing for each width.
// Directed literal checks on the 16-bit instance pin the model's arithmetic and timing.

module tb_cla4_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        ci = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        rdy4, dn4, co4, ov4;
    logic [3:0]  s4;
    logic        rdy16, dn16, co16, ov16;
    logic [15:0] s16;
    logic        rdy32, dn32, co32, ov32;
    logic [31:0] s32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cla4_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[3:0]), .b(b[3:0]),
        .carryInput(ci), .ready(rdy4), .done(dn4), .sum(s4), .carryOutput(co4), .overflow(ov4));
    cla4_serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]),
        .carryInput(ci), .ready(rdy16), .done(dn16), .sum(s16), .carryOutput(co16), .overflow(ov16));
    cla4_serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .carryInput(ci), .ready(rdy32), .done(dn32), .sum(s32), .carryOutput(co32), .overflow(ov32));

    logic [31:0] oSum[3];
    logic        oRdy[3], oDn[3], oCo[3], oOv[3];
    assign oSum[0] = {28'd0, s4};
    assign oSum[1] = {16'd0, s16};
    assign oSum[2] = s32;
    assign oRdy[0] = rdy4;  assign oRdy[1] = rdy16; assign oRdy[2] = rdy32;
    assign oDn[0]  = dn4;   assign oDn[1]  = dn16;  assign oDn[2]  = dn32;
    assign oCo[0]  = co4;   assign oCo[1]  = co16;  assign oCo[2]  = co32;
    assign oOv[0]  = ov4;   assign oOv[1]  = ov16;  assign oOv[2]  = ov32;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Plain-integer reference: returns {overflow, carry, sum} for a w-bit add or subtract.
    function automatic logic [33:0] refAdd(input int w, input logic [31:0] x, input logic [31:0] y,
                                           input logic sub, input logic cin);
        longint unsigned mask, xa, ya, tot, s;
        logic carry, sa, sb, ss, ov;
        mask  = (64'd1 << w) - 64'd1;
        xa    = {32'd0, x} & mask;
        ya    = (sub ? {32'd0, ~y} : {32'd0, y}) & mask;
        tot   = xa + ya + (sub ? 64'd1 : {63'd0, cin});
        s     = tot & mask;
        carry = tot[w];
        sa    = xa[w-1];
        sb    = ya[w-1];
        ss    = s[w-1];
        ov    = (sa == sb) && (ss != sa);
        return {ov, carry, s[31:0]};
    endfunction

    // Model state per width: busy count-down, pending result, and last published result.
    int          wid[3]  = '{4, 16, 32};
    int          nib[3]  = '{1, 4, 8};
    bit          busy[3] = '{default: 0};
    int          rem[3]  = '{default: 0};
    logic [31:0] pSum[3] = '{default: 0};
    logic [31:0] hSum[3] = '{default: 0};
    bit          pCo[3]  = '{default: 0};
    bit          pOv[3]  = '{default: 0};
    bit          hCo[3]  = '{default: 0};
    bit          hOv[3]  = '{default: 0};
    bit          eDn[3]  = '{default: 0};

    always @(posedge clk or negedge rst_n) begin : model
        logic [33:0] r;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                busy[k] = 0; rem[k] = 0; eDn[k] = 0;
                hSum[k] = '0; hCo[k] = 0; hOv[k] = 0;
            end else begin
                eDn[k] = 0;
                if (busy[k]) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        busy[k] = 0;
                        hSum[k] = pSum[k]; hCo[k] = pCo[k]; hOv[k] = pOv[k];
                        eDn[k]  = 1;
                    end
                end else if (start) begin
                    r       = refAdd(wid[k], a, b, op, ci);
                    pSum[k] = r[31:0]; pCo[k] = r[32]; pOv[k] = r[33];
                    busy[k] = 1;
                    rem[k]  = nib[k];
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("w%0d_ready", wid[k]), {31'd0, oRdy[k]}, {31'd0, !busy[k]});
            chk($sformatf("w%0d_done", wid[k]),  {31'd0, oDn[k]},  {31'd0, eDn[k]});
            chk($sformatf("w%0d_sum", wid[k]),   oSum[k],          hSum[k]);
            chk($sformatf("w%0d_cout", wid[k]),  {31'd0, oCo[k]},  {31'd0, hCo[k]});
            chk($sformatf("w%0d_ovf", wid[k]),   {31'd0, oOv[k]},  {31'd0, hOv[k]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAllReady();
        int n = 0;
        while (!(rdy4 && rdy16 && rdy32) && n < 30) begin
            tick();
            n++;
        end
        chk("ready_wait_bound", {31'd0, (rdy4 && rdy16 && rdy32)}, 32'd1);
    endtask

    task automatic runOp16(input string nm, input logic [15:0] x, input logic [15:0] y,
                           input logic o, input logic c, input logic [15:0] expS,
                           input logic expC, input logic expV);
        int lat = 0;
        int low = 0;
        a = {16'd0, x}; b = {16'd0, y}; op = o; ci = c; start = 1'b1;
        tick();
        start = 1'b0;
        while (!dn16 && lat < 20) begin
            if (!rdy16) low++;
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_ready_low"}, low, 4);
        chk({nm, "_sum"}, {16'd0, s16}, {16'd0, expS});
        chk({nm, "_cout"}, {31'd0, co16}, {31'd0, expC});
        chk({nm, "_ovf"}, {31'd0, ov16}, {31'd0, expV});
    endtask

    task automatic sweepOp(input logic [31:0] x, input logic [31:0] y, input logic o, input logic c);
        int n = 0;
        int l4 = -1;
        int l32 = -1;
        waitAllReady();
        a = x; b = y; op = o; ci = c; start = 1'b1;
        tick();
        start = 1'b0;
        while ((l4 < 0 || l32 < 0) && n < 30) begin
            tick();
            n++;
            if (dn4 && l4 < 0) l4 = n;
            if (dn32 && l32 < 0) l32 = n;
        end
        chk("w4_latency", l4, 1);
        chk("w32_latency", l32, 8);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d1, d2, seen;
        logic [15:0] r1, r2;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_ready", {31'd0, rdy16}, 32'd1);
        chk("rst_done",  {31'd0, dn16},  32'd0);
        chk("rst_sum",   {16'd0, s16},   32'd0);
        tick();

        runOp16("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        waitAllReady();
        runOp16("carry_chain", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        waitAllReady();
        runOp16("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        waitAllReady();
        runOp16("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        waitAllReady();

        // Back-to-back with start held; operands scrambled except at the two accepting edges.
        d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        a = 32'h1234; b = 32'h1111; op = 1'b0; ci = 1'b0; start = 1'b1;
        tick();
        for (int e = 1; e <= 11; e++) begin
            start = (e <= 9);
            a = (e == 5) ? 32'h0F0F : $urandom;
            b = (e == 5) ? 32'h00F1 : $urandom;
            tick();
            if (dn16) begin
                if (d1 < 0) begin d1 = e; r1 = s16; end
                else        begin d2 = e; r2 = s16; end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", d1, 4);
        chk("b2b_second_done", d2, 9);
        chk("b2b_first_sum", {16'd0, r1}, 32'h2345);
        chk("b2b_second_sum", {16'd0, r2}, 32'h1000);
        waitAllReady();

        runOp16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        waitAllReady();

        // Reset in the second RUN cycle must clear outputs at once and suppress done.
        a = 32'h1111; b = 32'h2222; op = 1'b0; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {31'd0, rdy16}, 32'd1);
        chk("async_rst_sum",   {16'd0, s16},   32'd0);
        chk("async_rst_cout",  {31'd0, co16},  32'd0);
        chk("async_rst_ovf",   {31'd0, ov16},  32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dn16) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        runOp16("post_rst", 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);

        // Wide/narrow instances: one pinned case, then random add/subtract traffic.
        sweepOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("w32_wrap_sum",  s32,            32'h0);
        chk("w32_wrap_cout", {31'd0, co32},  32'd1);
        chk("w32_wrap_ovf",  {31'd0, ov32},  32'd0);
        chk("w4_wrap_sum",   {28'd0, s4},    32'h0);
        chk("w4_wrap_cout",  {31'd0, co4},   32'd1);
        for (int i = 0; i < 1000; i++) begin
            sweepOp((i % 4 == 0) ? 32'h8000_0000 : $urandom,
                    (i % 8 == 1) ? 32'h7FFF_FFFF : $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        waitAllReady();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
